// File: rtl/sc_nibble_refresh_ctrl_if.sv
// Byte-producer to nibble-refresh-controller bus: byte handshake in, multiplexed digit drive out.
interface sc_nibble_refresh_ctrl_if #(
  parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] SC_NIBBLE_data_InBUS;
    logic                 SC_NIBBLE_valid_In;
    logic                 SC_NIBBLE_ready_Out;
    logic [3:0]           SC_NIBBLE_nibble_OutBUS;
    logic [1:0]           SC_NIBBLE_digit_OutBUS;
    logic                 SC_NIBBLE_frame_Out;

    modport master (
        output SC_NIBBLE_data_InBUS,
        output SC_NIBBLE_valid_In,
        input  SC_NIBBLE_ready_Out,
        input  SC_NIBBLE_nibble_OutBUS,
        input  SC_NIBBLE_digit_OutBUS,
        input  SC_NIBBLE_frame_Out
    );

    modport slave (
        input  SC_NIBBLE_data_InBUS,
        input  SC_NIBBLE_valid_In,
        output SC_NIBBLE_ready_Out,
        output SC_NIBBLE_nibble_OutBUS,
        output SC_NIBBLE_digit_OutBUS,
        output SC_NIBBLE_frame_Out
    );
endinterface

// File: rtl/sc_nibble_refresh_ctrl.sv
// Two-digit nibble refresh controller: shows byte low nibble then high nibble, new bytes only at frame end.
// Optional macro SC_NIBBLE_BLANK_EN blanks the high digit when its nibble is zero.
module sc_nibble_refresh_ctrl #(
    parameter int DATAWIDTH   = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int CNTWIDTH    = 16
) (
    input  logic                        SC_NIBBLE_CLOCK_50,
    input  logic                        SC_NIBBLE_RESET_InHigh,
    sc_nibble_refresh_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_LO = 2'd1,
        SHOW_HI = 2'd2
    } state_t;

    localparam logic [CNTWIDTH-1:0] LAST_CNT = CNTWIDTH'(REFRESH_DIV - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNTWIDTH-1:0]   r_cnt;
    logic [CNTWIDTH-1:0]   w_cnt_nxt;
    logic [7:0]            r_byte;
    logic [7:0]            w_byte_nxt;
    logic [DATAWIDTH-1:0]  w_data;
    logic                  w_last;
    logic                  w_ready;
    logic [3:0]            w_nibble;
    logic [1:0]            w_digit;
    logic                  w_frame;

    assign w_data = bus.SC_NIBBLE_data_InBUS;
    assign w_last = (r_cnt == LAST_CNT);

    always_ff @(posedge SC_NIBBLE_CLOCK_50 or posedge SC_NIBBLE_RESET_InHigh) begin
        if (SC_NIBBLE_RESET_InHigh) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_byte_nxt  = r_byte;
        w_ready     = 1'b0;
        w_nibble    = 4'h0;
        w_digit     = 2'b00;
        w_frame     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.SC_NIBBLE_valid_In) begin
                    w_byte_nxt  = w_data[7:0];
                    w_state_nxt = SHOW_LO;
                    w_cnt_nxt   = '0;
                end
            end
            SHOW_LO: begin
                w_digit  = 2'b01;
                w_nibble = r_byte[3:0];
                if (w_last) begin
                    w_state_nxt = SHOW_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            SHOW_HI: begin
                w_digit  = 2'b10;
                w_nibble = r_byte[7:4];
`ifdef SC_NIBBLE_BLANK_EN
                if (r_byte[7:4] == 4'h0) begin
                    w_digit  = 2'b00;
                    w_nibble = 4'h0;
                end
`endif
                // Frame end is the only acceptance point; without a new byte the old one is redisplayed.
                if (w_last) begin
                    w_ready     = 1'b1;
                    w_frame     = 1'b1;
                    w_state_nxt = SHOW_LO;
                    w_cnt_nxt   = '0;
                    if (bus.SC_NIBBLE_valid_In) begin
                        w_byte_nxt = w_data[7:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.SC_NIBBLE_ready_Out     = w_ready;
    assign bus.SC_NIBBLE_nibble_OutBUS = w_nibble;
    assign bus.SC_NIBBLE_digit_OutBUS  = w_digit;
    assign bus.SC_NIBBLE_frame_Out     = w_frame;

endmodule
